// File: rtl/regfile_sb.sv
// Register file with pending scoreboard for decode-stage RAW hazard detection.
// Latency: writes commit on the clock edge; reads are registered (1 cycle), with write-to-read bypass.
// Backpressure: none; the block always accepts. rd_busy1/2 tell decode to stall on a pending source.
module regfile_sb #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                ZERO_REG  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  // decode read ports
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  // write-back port
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  // issue port: marks a destination as pending
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              any_pending
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [DEPTH-1:0]  pend_clr;   // pending after write-clear, before issue-set

  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
  logic              rd_busy1_q, rd_busy1_d;
  logic              rd_busy2_q, rd_busy2_d;
  logic              any_pending_q, any_pending_d;

  logic              wr_ok;
  logic              iss_ok;

  // Next-state for storage, scoreboard and read registers. Reads observe
  // mem_d so a same-edge write is bypassed straight to the read port; busy
  // observes pend_clr so the consumer's own same-cycle issue is not seen.
  always_comb begin
    wr_ok         = wr_en && !(ZR && (wr_addr == '0));
    iss_ok        = issue_en && !(ZR && (issue_addr == '0));

    mem_d         = mem_q;
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end

    pend_clr      = pend_q;
    if (wr_en) begin
      pend_clr[wr_addr] = 1'b0;
    end
    pend_d        = pend_clr;
    if (iss_ok) begin
      pend_d[issue_addr] = 1'b1;
    end

    rd_data1_d    = rd_data1_q;
    rd_data2_d    = rd_data2_q;
    rd_busy1_d    = rd_busy1_q;
    rd_busy2_d    = rd_busy2_q;
    if (rd_en) begin
      rd_data1_d  = (ZR && (rd_addr1 == '0)) ? '0 : mem_d[rd_addr1];
      rd_data2_d  = (ZR && (rd_addr2 == '0)) ? '0 : mem_d[rd_addr2];
      rd_busy1_d  = pend_clr[rd_addr1];
      rd_busy2_d  = pend_clr[rd_addr2];
    end

    any_pending_d = |pend_d;
  end

  // Storage array; register 0 resets to zero when it is hardwired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (ZR && (i == 0)) ? '0 : RESET_VAL;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Scoreboard and registered read-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q        <= '0;
      rd_data1_q    <= '0;
      rd_data2_q    <= '0;
      rd_busy1_q    <= 1'b0;
      rd_busy2_q    <= 1'b0;
      any_pending_q <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      rd_data1_q    <= rd_data1_d;
      rd_data2_q    <= rd_data2_d;
      rd_busy1_q    <= rd_busy1_d;
      rd_busy2_q    <= rd_busy2_d;
      any_pending_q <= any_pending_d;
    end
  end

  assign rd_data1    = rd_data1_q;
  assign rd_data2    = rd_data2_q;
  assign rd_busy1    = rd_busy1_q;
  assign rd_busy2    = rd_busy2_q;
  assign any_pending = any_pending_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: instance a has RESET_VAL=5 and a hardwired zero register,
// instance b has RESET_VAL=0 and an ordinary register 0. Both share all inputs.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_regfile_sb;

  logic       clk;
  logic       rst_n;
  logic       rd_en;
  logic [3:0] rd_addr1, rd_addr2;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       issue_en;
  logic [3:0] issue_addr;

  logic [7:0] a_rd_data1, a_rd_data2, b_rd_data1, b_rd_data2;
  logic       a_rd_busy1, a_rd_busy2, b_rd_busy1, b_rd_busy2;
  logic       a_any_pending, b_any_pending;

  int n_checks;
  int n_fail;

  regfile_sb #(.DATA_W(8), .ADDR_W(4), .RESET_VAL(8'h05), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
    .rd_busy1(a_rd_busy1), .rd_busy2(a_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .any_pending(a_any_pending)
  );

  regfile_sb #(.DATA_W(8), .ADDR_W(4), .RESET_VAL(8'h00), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
    .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .any_pending(b_any_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; issue_en = 0;
    rd_addr1 = 0; rd_addr2 = 0; wr_addr = 0; wr_data = 0; issue_addr = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #12;
    n_checks++; if (a_rd_data1 !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data1 got %h exp 00", a_rd_data1); end
    n_checks++; if ({a_rd_busy1, a_rd_busy2, a_any_pending} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {a_rd_busy1, a_rd_busy2, a_any_pending}); end
    @(negedge clk);
    rst_n = 1;
    cyc();
    rd_en = 1; rd_addr1 = 4'd3; rd_addr2 = 4'd9;
    cyc();
    rd_en = 0;
    n_checks++; if (a_rd_data1 !== 8'h05) begin n_fail++; $display("FAIL resetval_r3 got %h exp 05", a_rd_data1); end
    n_checks++; if (a_rd_data2 !== 8'h05) begin n_fail++; $display("FAIL resetval_r9 got %h exp 05", a_rd_data2); end
    n_checks++; if ({a_rd_busy1, a_rd_busy2, a_any_pending} !== 3'b000) begin n_fail++; $display("FAIL resetval_flags got %b exp 000", {a_rd_busy1, a_rd_busy2, a_any_pending}); end
    n_checks++; if (b_rd_data1 !== 8'h00) begin n_fail++; $display("FAIL b_resetval_r3 got %h exp 00", b_rd_data1); end
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 4'd4; wr_data = 8'hA7;
    cyc();
    wr_en = 0; rd_en = 1; rd_addr1 = 4'd4; rd_addr2 = 4'd3;
    cyc();
    n_checks++; if (a_rd_data1 !== 8'hA7) begin n_fail++; $display("FAIL write_then_read got %h exp a7", a_rd_data1); end
    // bypass: write and read r6 in the same cycle
    wr_en = 1; wr_addr = 4'd6; wr_data = 8'h3C; rd_addr2 = 4'd6;
    cyc();
    n_checks++; if (a_rd_data2 !== 8'h3C) begin n_fail++; $display("FAIL bypass got %h exp 3c", a_rd_data2); end
    n_checks++; if (a_rd_data1 !== 8'hA7) begin n_fail++; $display("FAIL bypass_other_port got %h exp a7", a_rd_data1); end
    // rd_en low: outputs hold even though addresses change
    wr_en = 0; rd_en = 0; rd_addr1 = 4'd6; rd_addr2 = 4'd4;
    cyc();
    n_checks++; if ({a_rd_data1, a_rd_data2} !== {8'hA7, 8'h3C}) begin n_fail++; $display("FAIL hold got %h exp a73c", {a_rd_data1, a_rd_data2}); end
    // both ports on the same address
    rd_en = 1; rd_addr1 = 4'd6; rd_addr2 = 4'd6;
    cyc();
    rd_en = 0;
    n_checks++; if ({a_rd_data1, a_rd_data2} !== {8'h3C, 8'h3C}) begin n_fail++; $display("FAIL same_addr got %h exp 3c3c", {a_rd_data1, a_rd_data2}); end
  endtask

  task automatic test_zero_reg();
    wr_en = 1; wr_addr = 4'd0; wr_data = 8'hFF; issue_en = 1; issue_addr = 4'd0;
    cyc();
    wr_en = 0; issue_en = 0;
    n_checks++; if (a_any_pending !== 1'b0) begin n_fail++; $display("FAIL zr_any_pending got %b exp 0", a_any_pending); end
    n_checks++; if (b_any_pending !== 1'b1) begin n_fail++; $display("FAIL b_r0_any_pending got %b exp 1", b_any_pending); end
    rd_en = 1; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    cyc();
    n_checks++; if ({a_rd_data1, a_rd_data2} !== 16'h0000) begin n_fail++; $display("FAIL zr_read got %h exp 0000", {a_rd_data1, a_rd_data2}); end
    n_checks++; if ({a_rd_busy1, a_rd_busy2} !== 2'b00) begin n_fail++; $display("FAIL zr_busy got %b exp 00", {a_rd_busy1, a_rd_busy2}); end
    n_checks++; if ({b_rd_data1, b_rd_busy1} !== {8'hFF, 1'b1}) begin n_fail++; $display("FAIL b_r0_read got %h exp ff/1", {b_rd_data1, b_rd_busy1}); end
    // write-back to r0 while reading it: b clears and bypasses, a still reads 0
    wr_en = 1; wr_addr = 4'd0; wr_data = 8'h12;
    cyc();
    wr_en = 0; rd_en = 0;
    n_checks++; if ({a_rd_data1, a_rd_busy1} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL zr_read_wr got %h exp 00/0", {a_rd_data1, a_rd_busy1}); end
    n_checks++; if ({b_rd_data1, b_rd_busy1, b_any_pending} !== {8'h12, 1'b0, 1'b0}) begin n_fail++; $display("FAIL b_r0_clear got %h exp 12/0/0", {b_rd_data1, b_rd_busy1, b_any_pending}); end
  endtask

  task automatic test_scoreboard();
    issue_en = 1; issue_addr = 4'd5;
    cyc();
    issue_en = 0;
    n_checks++; if (a_any_pending !== 1'b1) begin n_fail++; $display("FAIL sb_any_set got %b exp 1", a_any_pending); end
    rd_en = 1; rd_addr1 = 4'd5; rd_addr2 = 4'd4;
    cyc();
    n_checks++; if ({a_rd_busy1, a_rd_busy2} !== 2'b10) begin n_fail++; $display("FAIL sb_busy got %b exp 10", {a_rd_busy1, a_rd_busy2}); end
    wr_en = 1; wr_addr = 4'd5; wr_data = 8'h5A;
    cyc();
    wr_en = 0; rd_en = 0;
    n_checks++; if ({a_rd_data1, a_rd_busy1} !== {8'h5A, 1'b0}) begin n_fail++; $display("FAIL sb_clear_read got %h exp 5a/0", {a_rd_data1, a_rd_busy1}); end
    n_checks++; if (a_any_pending !== 1'b0) begin n_fail++; $display("FAIL sb_any_fall got %b exp 0", a_any_pending); end
    // write to a non-pending register leaves the scoreboard alone
    wr_en = 1; wr_addr = 4'd9; wr_data = 8'h99;
    cyc();
    wr_en = 0;
    n_checks++; if (a_any_pending !== 1'b0) begin n_fail++; $display("FAIL sb_wr_nonpending got %b exp 0", a_any_pending); end
  endtask

  task automatic test_same_cycle();
    // issue and write-back to r7 together: set wins
    issue_en = 1; issue_addr = 4'd7; wr_en = 1; wr_addr = 4'd7; wr_data = 8'h77;
    cyc();
    issue_en = 0; wr_en = 0;
    n_checks++; if (a_any_pending !== 1'b1) begin n_fail++; $display("FAIL same_any got %b exp 1", a_any_pending); end
    // read r7 and issue r8 while reading r8: own-destination issue not visible
    rd_en = 1; rd_addr1 = 4'd7; rd_addr2 = 4'd8; issue_en = 1; issue_addr = 4'd8;
    cyc();
    issue_en = 0;
    n_checks++; if ({a_rd_data1, a_rd_busy1} !== {8'h77, 1'b1}) begin n_fail++; $display("FAIL same_r7 got %h exp 77/1", {a_rd_data1, a_rd_busy1}); end
    n_checks++; if (a_rd_busy2 !== 1'b0) begin n_fail++; $display("FAIL issue_not_seen got %b exp 0", a_rd_busy2); end
    // re-issue r8 (already pending) then read it
    issue_en = 1; issue_addr = 4'd8;
    cyc();
    issue_en = 0;
    n_checks++; if (a_rd_busy2 !== 1'b1) begin n_fail++; $display("FAIL reissue_busy got %b exp 1", a_rd_busy2); end
    // one write-back clears r8 fully despite two issues
    wr_en = 1; wr_addr = 4'd8; wr_data = 8'h88;
    cyc();
    wr_en = 0;
    n_checks++; if ({a_rd_data2, a_rd_busy2, a_rd_busy1} !== {8'h88, 1'b0, 1'b1}) begin n_fail++; $display("FAIL r8_clear got %h exp 88/0/1", {a_rd_data2, a_rd_busy2, a_rd_busy1}); end
    rd_en = 0;
  endtask

  task automatic test_async_reset();
    wr_en = 1; wr_addr = 4'd1; wr_data = 8'h11;
    cyc();
    wr_en = 0;
    rd_en = 1; rd_addr1 = 4'd1; rd_addr2 = 4'd2; issue_en = 1; issue_addr = 4'd2;
    cyc();
    rd_en = 0; issue_en = 0;
    n_checks++; if ({a_rd_data1, a_any_pending} !== {8'h11, 1'b1}) begin n_fail++; $display("FAIL pre_reset got %h exp 11/1", {a_rd_data1, a_any_pending}); end
    #2;
    rst_n = 0;
    #1;
    n_checks++; if ({a_rd_data1, a_rd_data2, a_rd_busy1, a_rd_busy2, a_any_pending} !== 19'h0) begin n_fail++; $display("FAIL async_reset got %h exp 0", {a_rd_data1, a_rd_data2, a_rd_busy1, a_rd_busy2, a_any_pending}); end
    #2;
    rst_n = 1;
    cyc();
    rd_en = 1; rd_addr1 = 4'd2; rd_addr2 = 4'd1;
    cyc();
    rd_en = 0;
    n_checks++; if ({a_rd_data1, a_rd_data2} !== {8'h05, 8'h05}) begin n_fail++; $display("FAIL post_reset_data got %h exp 0505", {a_rd_data1, a_rd_data2}); end
    n_checks++; if ({a_rd_busy1, a_rd_busy2, a_any_pending} !== 3'b000) begin n_fail++; $display("FAIL post_reset_flags got %b exp 000", {a_rd_busy1, a_rd_busy2, a_any_pending}); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_same_cycle();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 8-bit/16-entry register file.
- Adds synchronous writes, two registered read ports, write-to-read bypass, an optional hardwired zero register, and a per-register pending scoreboard used by the decode stage for RAW hazard stalls.
- Sits between decode (read ports, issue) and write-back (write port).

Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- RESET_VAL, 0, value loaded into every register on reset
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, never pending

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  sample both read ports this cycle
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  registered read data, port 1
- rd_data2  out  DATA_W  registered read data, port 2
- rd_busy1  out  1  registered pending flag for rd_addr1
- rd_busy2  out  1  registered pending flag for rd_addr2
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write-back address
- wr_data  in  DATA_W  write-back data
- issue_en  in  1  mark issue_addr pending (producer issued)
- issue_addr  in  ADDR_W  destination being issued
- any_pending  out  1  OR of all pending bits, registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = RESET_VAL (register 0 = 0 if ZERO_REG)
  - all pending bits = 0
  - rd_data1/2 = 0, rd_busy1/2 = 0, any_pending = 0
  - takes effect immediately, mid-operation included; the first edge after deassertion operates normally.
- Write:
  - on the rising edge with wr_en = 1, mem[wr_addr] <= wr_data.
  - ignored when ZERO_REG = 1 and wr_addr = 0.
- Read:
  - 1-cycle latency. On an edge with rd_en = 1, rd_dataN <= value of mem[rd_addrN] after that edge's write.
  - Bypass: if wr_en and wr_addr == rd_addrN (and the write is not suppressed), rd_dataN <= wr_data.
  - Both ports may use the same address; they return identical data.
  - With ZERO_REG = 1, address 0 returns 0.
  - rd_en = 0: rd_data1/2 and rd_busy1/2 hold their previous values.
- Scoreboard, updated every edge:
  - pending[wr_addr] cleared when wr_en.
  - pending[issue_addr] set when issue_en.
  - Same address in the same cycle: set wins; the register stays pending for the new producer.
  - issue_en to an already-pending register leaves it set; no counting.
  - wr_en to a non-pending register writes data; pending unchanged.
  - ZERO_REG = 1: address 0 never becomes pending.
- Busy flags:
  - on an edge with rd_en, rd_busyN <= pending[rd_addrN] after the write-clear, before the same-cycle set.
  - A same-cycle issue_en is not reflected (it is the consumer's own destination).
  - A same-cycle matching write shows busy = 0.
- any_pending: registered OR of the pending vector after the full update (clear then set).
- Width rules:
  - all addresses are used unsigned at full width; no out-of-range case exists.
  - data is stored unmodified.

Test Plan:
- Reset with RESET_VAL = 8'h05; release; read addr 3 and 9 -> rd_data1 = 8'h05, rd_data2 = 8'h05 one cycle after rd_en, busy flags 0, any_pending 0.
- Write 8'hA7 to r4 at cycle N, read r4 at N+1 -> rd_data1 = 8'hA7 at N+2. Write 8'h3C to r6 and read r6 in the same cycle N -> rd_data2 = 8'h3C at N+1 (bypass).
- ZERO_REG = 1: write 8'hFF to r0 and issue r0 -> reads of r0 return 0, rd_busy 0, any_pending stays 0.
- Scoreboard:
  - issue r5 at N, read r5 at N+1 -> rd_busy1 = 1.
  - Write r5 at N+2 while reading r5 -> rd_busy1 = 0 with new data at N+3.
  - any_pending falls at N+3.
- Issue r7 and write r7 in the same cycle -> pending stays set; the next read of r7 shows busy 1 and the written data.
- Pull rst_n low asynchronously between edges while r2 is pending and rd_data1 = 8'h11 -> outputs go to 0 immediately, pending clears, r2 reads RESET_VAL after release.
